// File: rtl/mips_fetch_queue.sv
// mips_fetch_queue: PC generator plus in-order prefetch queue for the
// pipelined MIPS core. Requests go out on a valid/ready port and responses
// come back in order. Decode pops the queue head, and redirects flush it.
//
// Handshake semantics: an imem request transfers in any cycle where
// imem_req_valid && imem_req_ready. Each accepted request produces exactly
// one imem_resp_valid pulse, in order and no earlier than the next cycle.
// Decode consumes the head in any cycle where instr_valid_d && !stall_d.
//
// Optional feature: define MIPS_FETCH_PERF_EN to add the perf_redirects and
// perf_dropped event counters.
module mips_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         imem_req_valid,
    input  logic                         imem_req_ready,
    output logic [XLEN-1:0]              imem_addr,
    input  logic                         imem_resp_valid,
    input  logic [31:0]                  imem_resp_data,
    input  logic                         redirect,
    input  logic [XLEN-1:0]              redirect_pc,
    input  logic                         stall_d,
    output logic                         instr_valid_d,
    output logic [31:0]                  instr_d,
    output logic [XLEN-1:0]              pc_plus4_d,
    output logic [$clog2(DEPTH+1)-1:0]   q_count
`ifdef MIPS_FETCH_PERF_EN
    ,
    output logic [31:0]                  perf_redirects,
    output logic [31:0]                  perf_dropped
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   drop_q, drop_d;

    logic [XLEN-1:0] pc_mem_q   [DEPTH];
    logic [31:0]     data_mem_q [DEPTH];

    logic            credit_ok;
    logic            req_fire;
    logic            push;
    logic            pop;
    logic            resp_discard;
    logic [XLEN-1:0] redirect_tgt;

    // Request credit counts queued words plus in-flight requests, so a
    // response always finds a free slot.
    assign credit_ok      = ({1'b0, count_q} + {1'b0, outst_q}) < (CW+1)'(DEPTH);
    assign imem_req_valid = !reset && !redirect && credit_ok;
    assign imem_addr      = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response is discarded when it belongs to a pre-redirect request
    // (drop_q != 0) or arrives in the redirect cycle itself.
    assign resp_discard   = imem_resp_valid && (redirect || (drop_q != '0));
    assign push           = imem_resp_valid && !redirect && (drop_q == '0);
    assign pop            = (count_q != '0) && !stall_d && !redirect;
    assign redirect_tgt   = redirect_pc & ~XLEN'(3);

    // Head outputs. With an empty queue, pc_plus4_d shows the next PC to be
    // pushed, which gives RESET_PC+4 out of reset.
    assign q_count        = count_q;
    assign instr_valid_d  = (count_q != '0);
    assign instr_d        = instr_valid_d ? data_mem_q[rd_ptr_q] : 32'h0;
    assign pc_plus4_d     = (instr_valid_d ? pc_mem_q[rd_ptr_q] : resp_pc_q) + XLEN'(4);

    // Next-state logic: fetch PC, queue pointers, occupancy, outstanding and
    // drop counters. Redirect overrides everything computed before it.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        outst_d    = outst_q + CW'(req_fire) - CW'(imem_resp_valid);
        drop_d     = drop_q;

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
        if (push) begin
            wr_ptr_d  = wr_ptr_q + PW'(1);
            resp_pc_d = resp_pc_q + XLEN'(4);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
        if (imem_resp_valid && !redirect && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end

        if (redirect) begin
            // Every request still in flight after this cycle is stale. No
            // request is issued this cycle, so that is exactly outst_d.
            fetch_pc_d = redirect_tgt;
            resp_pc_d  = redirect_tgt;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            drop_d     = outst_q - CW'(imem_resp_valid);
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    // Queue storage. Entries need no reset because the occupancy gates the head.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= resp_pc_q;
            data_mem_q[wr_ptr_q] <= imem_resp_data;
        end
    end

`ifdef MIPS_FETCH_PERF_EN
    logic [31:0] perf_redirects_q, perf_redirects_d;
    logic [31:0] perf_dropped_q, perf_dropped_d;

    // Event counters. Both wrap naturally at 2^32.
    always_comb begin
        perf_redirects_d = perf_redirects_q + 32'(redirect);
        perf_dropped_d   = perf_dropped_q + 32'(resp_discard);
    end

    // Event counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_redirects_q <= '0;
            perf_dropped_q   <= '0;
        end else begin
            perf_redirects_q <= perf_redirects_d;
            perf_dropped_q   <= perf_dropped_d;
        end
    end

    assign perf_redirects = perf_redirects_q;
    assign perf_dropped   = perf_dropped_q;
`else
    logic unused_discard;
    assign unused_discard = resp_discard;
`endif

endmodule

// File: tb/tb_mips_fetch_queue.sv
// Directed testbench for mips_fetch_queue (default parameters: XLEN=32,
// DEPTH=4, RESET_PC=0). The imem model returns addr ^ DATA_KEY as the
// instruction word, with a programmable response latency.
module tb_mips_fetch_queue;

    localparam logic [31:0] DATA_KEY = 32'hDEAD_0000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall_d;
    logic        instr_valid_d;
    logic [31:0] instr_d;
    logic [31:0] pc_plus4_d;
    logic [2:0]  q_count;
`ifdef MIPS_FETCH_PERF_EN
    logic [31:0] perf_redirects;
    logic [31:0] perf_dropped;
`endif

    mips_fetch_queue dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .stall_d         (stall_d),
        .instr_valid_d   (instr_valid_d),
        .instr_d         (instr_d),
        .pc_plus4_d      (pc_plus4_d),
        .q_count         (q_count)
`ifdef MIPS_FETCH_PERF_EN
        ,
        .perf_redirects  (perf_redirects),
        .perf_dropped    (perf_dropped)
`endif
    );

    // ---------------- scoreboard state ----------------
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];

    // imem model state
    int          lat = 1;
    int          cyc = 0;
    int          n_accept = 0;
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    // ---------------- driver tasks ----------------
    // One clock cycle: record the handshake, advance the clock, then present
    // the response (if one is due) for the new cycle.
    task automatic cycle();
        #1;
        if (imem_resp_valid) begin
            vectors++;
            if (q_count === 3'd4) begin
                miscompares++;
                $display("FAIL resp_into_full: q_count=%0d with response arriving, required <4", q_count);
            end
        end
        if (imem_req_valid && imem_req_ready) begin
            pend_addr.push_back(imem_addr);
            pend_due.push_back(cyc + lat);
            n_accept++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (reset) begin
            pend_addr.delete();
            pend_due.delete();
        end
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = pend_addr[0] ^ DATA_KEY;
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
    endtask

    task automatic do_reset(input int latency);
        reset           = 1'b1;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        redirect        = 1'b0;
        redirect_pc     = 32'h0;
        stall_d         = 1'b0;
        lat             = latency;
        pend_addr.delete();
        pend_due.delete();
        cycle();
        cycle();
        reset    = 1'b0;
        cyc      = 0;
        n_accept = 0;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset           = 1'b1;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        redirect        = 1'b0;
        redirect_pc     = 32'h0;
        stall_d         = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_req_valid: got %b required 0", imem_req_valid); end
        vectors++;
        if (q_count !== 3'd0) begin miscompares++; $display("FAIL reset_q_count: got %0d required 0", q_count); end
        vectors++;
        if (instr_valid_d !== 1'b0) begin miscompares++; $display("FAIL reset_instr_valid: got %b required 0", instr_valid_d); end
        vectors++;
        if (instr_d !== 32'h0) begin miscompares++; $display("FAIL reset_instr_d: got %h required 00000000", instr_d); end
        vectors++;
        if (pc_plus4_d !== 32'h4) begin miscompares++; $display("FAIL reset_pc_plus4: got %h required 00000004", pc_plus4_d); end
        vectors++;
        if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h required 00000000", imem_addr); end
`ifdef MIPS_FETCH_PERF_EN
        vectors++;
        if (perf_redirects !== 32'h0 || perf_dropped !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_perf: got %0d/%0d required 0/0", perf_redirects, perf_dropped);
        end
`endif
    endtask

    task automatic test_stream();
        do_reset(1);
        vectors++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
            miscompares++; $display("FAIL stream_first_req: valid=%b addr=%h required 1/00000000", imem_req_valid, imem_addr);
        end
        cycle();
        vectors++;
        if (instr_valid_d !== 1'b0 || imem_addr !== 32'h4) begin
            miscompares++; $display("FAIL stream_t1: valid=%b addr=%h required 0/00000004", instr_valid_d, imem_addr);
        end
        cycle();
        for (int i = 1; i <= 3; i++) begin
            vectors++;
            if (instr_valid_d !== 1'b1 || pc_plus4_d !== 32'(4 * i) || instr_d !== (32'(4 * (i - 1)) ^ DATA_KEY)) begin
                miscompares++;
                $display("FAIL stream_head%0d: valid=%b pc_plus4=%h instr=%h required 1/%h/%h",
                         i, instr_valid_d, pc_plus4_d, instr_d, 32'(4 * i), 32'(4 * (i - 1)) ^ DATA_KEY);
            end
            cycle();
        end
    endtask

    task automatic test_stall();
        do_reset(1);
        stall_d = 1'b1;
        repeat (8) cycle();
        vectors++;
        if (n_accept != 4) begin miscompares++; $display("FAIL stall_accepts: got %0d required 4", n_accept); end
        vectors++;
        if (q_count !== 3'd4 || imem_req_valid !== 1'b0) begin
            miscompares++; $display("FAIL stall_full: q_count=%0d req_valid=%b required 4/0", q_count, imem_req_valid);
        end
        for (int i = 1; i <= 6; i++) exp_q.push_back(32'(4 * i));
        stall_d = 1'b0;
        for (int i = 0; i < 6; i++) begin
            logic [31:0] exp_pc4;
            #1;
            exp_pc4 = exp_q.pop_front();
            vectors++;
            if (instr_valid_d !== 1'b1 || pc_plus4_d !== exp_pc4 || instr_d !== ((exp_pc4 - 32'h4) ^ DATA_KEY)) begin
                miscompares++;
                $display("FAIL stall_drain%0d: valid=%b pc_plus4=%h instr=%h required 1/%h/%h",
                         i, instr_valid_d, pc_plus4_d, instr_d, exp_pc4, (exp_pc4 - 32'h4) ^ DATA_KEY);
            end
            if (i == 1) begin
                vectors++;
                if (imem_req_valid !== 1'b1 || imem_addr !== 32'h10) begin
                    miscompares++; $display("FAIL stall_resume: valid=%b addr=%h required 1/00000010", imem_req_valid, imem_addr);
                end
            end
            cycle();
        end
    endtask

    task automatic test_redirect_drop();
        do_reset(3);
        cycle();
        cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        #1;
        vectors++;
        if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL redir_req_blocked: got %b required 0", imem_req_valid); end
        cycle();
        redirect = 1'b0;
        #1;
        vectors++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin
            miscompares++; $display("FAIL redir_target: valid=%b addr=%h required 1/00000100", imem_req_valid, imem_addr);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (q_count !== 3'd0 || instr_valid_d !== 1'b0) begin
                miscompares++; $display("FAIL redir_empty%0d: q_count=%0d valid=%b required 0/0", i, q_count, instr_valid_d);
            end
            cycle();
        end
        vectors++;
        if (instr_valid_d !== 1'b1 || pc_plus4_d !== 32'h104 || instr_d !== (32'h100 ^ DATA_KEY)) begin
            miscompares++; $display("FAIL redir_first_head: valid=%b pc_plus4=%h instr=%h required 1/00000104/%h",
                                    instr_valid_d, pc_plus4_d, instr_d, 32'h100 ^ DATA_KEY);
        end
        cycle();
        vectors++;
        if (pc_plus4_d !== 32'h108) begin miscompares++; $display("FAIL redir_second_head: got %h required 00000108", pc_plus4_d); end
`ifdef MIPS_FETCH_PERF_EN
        vectors++;
        if (perf_redirects !== 32'd1 || perf_dropped !== 32'd2) begin
            miscompares++; $display("FAIL redir_perf: got %0d/%0d required 1/2", perf_redirects, perf_dropped);
        end
`endif
    endtask

    task automatic test_redirect_resp_pop();
        do_reset(2);
        cycle();
        cycle();
        cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        #1;
        vectors++;
        if (instr_valid_d !== 1'b1 || imem_req_valid !== 1'b0) begin
            miscompares++; $display("FAIL rrp_setup: valid=%b req_valid=%b required 1/0", instr_valid_d, imem_req_valid);
        end
        cycle();
        redirect = 1'b0;
        #1;
        vectors++;
        if (q_count !== 3'd0 || instr_valid_d !== 1'b0 || imem_addr !== 32'h200) begin
            miscompares++; $display("FAIL rrp_flush: q_count=%0d valid=%b addr=%h required 0/0/00000200", q_count, instr_valid_d, imem_addr);
        end
        cycle();
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (q_count !== 3'd0) begin miscompares++; $display("FAIL rrp_empty%0d: got %0d required 0", i, q_count); end
            cycle();
        end
        vectors++;
        if (instr_valid_d !== 1'b1 || pc_plus4_d !== 32'h204) begin
            miscompares++; $display("FAIL rrp_first_head: valid=%b pc_plus4=%h required 1/00000204", instr_valid_d, pc_plus4_d);
        end
`ifdef MIPS_FETCH_PERF_EN
        vectors++;
        if (perf_redirects !== 32'd1 || perf_dropped !== 32'd2) begin
            miscompares++; $display("FAIL rrp_perf: got %0d/%0d required 1/2", perf_redirects, perf_dropped);
        end
`endif
    endtask

    task automatic test_wrap();
        do_reset(1);
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        cycle();
        redirect = 1'b0;
        #1;
        vectors++;
        if (imem_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_align: got %h required fffffffc", imem_addr); end
        cycle();
        vectors++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
            miscompares++; $display("FAIL wrap_addr: valid=%b addr=%h required 1/00000000", imem_req_valid, imem_addr);
        end
        cycle();
        vectors++;
        if (instr_valid_d !== 1'b1 || pc_plus4_d !== 32'h0 || instr_d !== (32'hFFFF_FFFC ^ DATA_KEY)) begin
            miscompares++; $display("FAIL wrap_head: valid=%b pc_plus4=%h instr=%h required 1/00000000/%h",
                                    instr_valid_d, pc_plus4_d, instr_d, 32'hFFFF_FFFC ^ DATA_KEY);
        end
        cycle();
        vectors++;
        if (pc_plus4_d !== 32'h4) begin miscompares++; $display("FAIL wrap_next_head: got %h required 00000004", pc_plus4_d); end
    endtask

    task automatic test_back_to_back();
        do_reset(3);
        cycle();
        cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        cycle();
        redirect_pc = 32'h400;
        #1;
        vectors++;
        if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_req_blocked: got %b required 0", imem_req_valid); end
        cycle();
        redirect = 1'b0;
        #1;
        vectors++;
        if (imem_addr !== 32'h400) begin miscompares++; $display("FAIL b2b_target: got %h required 00000400", imem_addr); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (q_count !== 3'd0) begin miscompares++; $display("FAIL b2b_empty%0d: got %0d required 0", i, q_count); end
            cycle();
        end
        vectors++;
        if (instr_valid_d !== 1'b1 || pc_plus4_d !== 32'h404) begin
            miscompares++; $display("FAIL b2b_first_head: valid=%b pc_plus4=%h required 1/00000404", instr_valid_d, pc_plus4_d);
        end
`ifdef MIPS_FETCH_PERF_EN
        vectors++;
        if (perf_redirects !== 32'd2 || perf_dropped !== 32'd2) begin
            miscompares++; $display("FAIL b2b_perf: got %0d/%0d required 2/2", perf_redirects, perf_dropped);
        end
`endif
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drop();
        test_redirect_resp_pop();
        test_wrap();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
